// File: rtl/jesd_tx_link_fsm.sv
// rtl/jesd_tx_link_fsm.sv - JESD204B transmit link sequencer (CGS, ILAS, DATA)
//
// Steps one lane through code group sync, the initial lane alignment
// sequence and user data, driving the octet mux select and ILAS markers.
// One frame is one clk cycle.
//
// Ports:
//   clk          device/frame clock
//   rst          asynchronous active-high reset
//   i_K          frames per multiframe minus one (static outside CGS)
//   i_lmfc_clk   one-cycle LMFC pulse
//   i_sync_n     SYNC~ from receiver (synchronized), low = sync request
//   o_tx_sel     octet source: 0 = /K/, 1 = ILAS, 2 = user data
//   o_ilas_mf    ILAS multiframe index
//   o_ilas_frame frame index within the ILAS multiframe
//   o_ilas_r     /R/ marker (first frame of an ILAS multiframe)
//   o_ilas_a     /A/ marker (last frame of an ILAS multiframe)
//   o_ilas_q     /Q/ marker (frame 1 of ILAS multiframe 1)
//   o_link_up    high while in DATA
module jesd_tx_link_fsm #(
    parameter int SYNC_ERR_LEN = 4,
    parameter int ILAS_MF      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_K,
    input  logic       i_lmfc_clk,
    input  logic       i_sync_n,
    output logic [1:0] o_tx_sel,
    output logic [1:0] o_ilas_mf,
    output logic [4:0] o_ilas_frame,
    output logic       o_ilas_r,
    output logic       o_ilas_a,
    output logic       o_ilas_q,
    output logic       o_link_up
);

    typedef enum logic [1:0] {
        ST_CGS       = 2'd0,
        ST_WAIT_LMFC = 2'd1,
        ST_ILAS      = 2'd2,
        ST_DATA      = 2'd3
    } state_t;

    localparam logic [3:0] SYNC_LEN_C = 4'(SYNC_ERR_LEN);
    localparam logic [1:0] MF_LAST_C  = 2'(ILAS_MF - 1);

    state_t     state_q, state_d;
    logic [4:0] frame_q, frame_d;
    logic [1:0] mf_q, mf_d;
    logic [3:0] sync_cnt_q, sync_cnt_d;
    logic [1:0] tx_sel_q, tx_sel_d;
    logic       r_q, r_d;
    logic       a_q, a_d;
    logic       q_q, q_d;
    logic       link_up_q, link_up_d;

    logic       in_link;
    logic       resync;
    logic       ilas_d;
    logic [3:0] sync_low_next;

    always_comb begin
        state_d    = state_q;
        frame_d    = 5'd0;
        mf_d       = 2'd0;
        sync_cnt_d = 4'd0;

        in_link       = (state_q == ST_ILAS) || (state_q == ST_DATA);
        sync_low_next = (sync_cnt_q == SYNC_LEN_C) ? SYNC_LEN_C : sync_cnt_q + 4'd1;
        resync        = in_link && !i_sync_n && (sync_low_next == SYNC_LEN_C);

        case (state_q)
            ST_CGS: begin
                if (i_sync_n) state_d = ST_WAIT_LMFC;
            end
            ST_WAIT_LMFC: begin
                // A sync request outranks a coincident LMFC pulse.
                if (!i_sync_n)       state_d = ST_CGS;
                else if (i_lmfc_clk) state_d = ST_ILAS;
            end
            ST_ILAS: begin
                if (frame_q == i_K) begin
                    if (mf_q == MF_LAST_C) state_d = ST_DATA;
                    else                   mf_d    = mf_q + 2'd1;
                end else begin
                    frame_d = frame_q + 5'd1;
                    mf_d    = mf_q;
                end
            end
            ST_DATA: begin
            end
            default: state_d = ST_CGS;
        endcase

        // Re-sync overrides everything, including the ILAS -> DATA step.
        if (resync) begin
            state_d = ST_CGS;
            frame_d = 5'd0;
            mf_d    = 2'd0;
        end else if (in_link && !i_sync_n) begin
            sync_cnt_d = sync_low_next;
        end

        ilas_d = (state_d == ST_ILAS);
        case (state_d)
            ST_ILAS: tx_sel_d = 2'd1;
            ST_DATA: tx_sel_d = 2'd2;
            default: tx_sel_d = 2'd0;
        endcase
        r_d       = ilas_d && (frame_d == 5'd0);
        a_d       = ilas_d && (frame_d == i_K);
        q_d       = ilas_d && (mf_d == 2'd1) && (frame_d == 5'd1);
        link_up_d = (state_d == ST_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CGS;
            frame_q    <= 5'd0;
            mf_q       <= 2'd0;
            sync_cnt_q <= 4'd0;
            tx_sel_q   <= 2'd0;
            r_q        <= 1'b0;
            a_q        <= 1'b0;
            q_q        <= 1'b0;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            mf_q       <= mf_d;
            sync_cnt_q <= sync_cnt_d;
            tx_sel_q   <= tx_sel_d;
            r_q        <= r_d;
            a_q        <= a_d;
            q_q        <= q_d;
            link_up_q  <= link_up_d;
        end
    end

    assign o_tx_sel     = tx_sel_q;
    assign o_ilas_mf    = mf_q;
    assign o_ilas_frame = frame_q;
    assign o_ilas_r     = r_q;
    assign o_ilas_a     = a_q;
    assign o_ilas_q     = q_q;
    assign o_link_up    = link_up_q;

endmodule

// File: doc/jesd_tx_link_fsm.md
# jesd_tx_link_fsm

Transmit-side JESD204B link-layer sequencer that sits directly downstream of the frame/LMFC clock generator. It consumes the one-cycle LMFC pulse and the receiver's SYNC~ request, and steps the lane through Code Group Synchronization (CGS), the 4-multiframe Initial Lane Alignment Sequence (ILAS) and user data. Its outputs drive the per-lane octet mux/scrambler (data source select plus ILAS control-character markers). One frame equals one `clk` cycle, matching the frame clock definition.

## Interface
- `SYNC_ERR_LEN`, default 4: consecutive `i_sync_n` low cycles (range 2..15) that force a re-sync from ILAS/DATA.
- `ILAS_MF`, default 4: number of ILAS multiframes (range 1..4).

- `clk`  in  1  device clock (= frame clock); all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_K`  in  5  frames per multiframe, binary value - 1 (0..31); same encoding as the LMFC generator; static outside CGS.
- `i_lmfc_clk`  in  1  one-cycle LMFC pulse from the frame/LMFC clock generator.
- `i_sync_n`  in  1  SYNC~ from receiver, already synchronized to `clk`; low = sync request.
- `o_tx_sel`  out  2  octet source: 0 = /K/ (K28.5), 1 = ILAS, 2 = user data; 3 never driven.
- `o_ilas_mf`  out  2  current ILAS multiframe index.
- `o_ilas_frame`  out  5  current frame index within the ILAS multiframe.
- `o_ilas_r`  out  1  first frame of an ILAS multiframe (/R/, K28.0).
- `o_ilas_a`  out  1  last frame of an ILAS multiframe (/A/, K28.3).
- `o_ilas_q`  out  1  frame 1 of ILAS multiframe 1 (/Q/, K28.4, start of link config).
- `o_link_up`  out  1  high in DATA state.

## Operation
- States: CGS, WAIT_LMFC, ILAS, DATA. All outputs registered, decoded from next-state.
- CGS: `o_tx_sel`=0. If `i_sync_n` sampled high -> WAIT_LMFC.
- WAIT_LMFC: `o_tx_sel`=0. `i_sync_n` sampled low -> CGS. Else `i_lmfc_clk` sampled high -> ILAS with mf=0, frame=0.
- ILAS: `o_tx_sel`=1. Frame counter 0..`i_K`, wraps to 0 and increments mf. After frame=`i_K` of mf=`ILAS_MF`-1 -> DATA.
- Markers: `o_ilas_r` = (frame==0); `o_ilas_a` = (frame==`i_K`); `o_ilas_q` = (mf==1 && frame==1). K=0: `o_ilas_r` and `o_ilas_a` both high every ILAS frame, `o_ilas_q` never asserts.
- DATA: `o_tx_sel`=2, `o_link_up`=1; remains until re-sync.
- Re-sync detector: counter of consecutive `i_sync_n` low samples, saturating at `SYNC_ERR_LEN`, cleared by any high sample; active in ILAS and DATA. Reaching `SYNC_ERR_LEN` -> CGS. Shorter low pulses (receiver error reports) are ignored.
- `o_ilas_mf`, `o_ilas_frame`, markers are 0 outside ILAS.
- Counter widths: frame 5 bits compared against the 5-bit `i_K` (no overflow since frame <= 31); mf 2 bits.

## Timing
- Reset (async assert, sync release): state CGS; `o_tx_sel`=0, `o_ilas_mf`=0, `o_ilas_frame`=0, `o_ilas_r`=0, `o_ilas_a`=0, `o_ilas_q`=0, `o_link_up`=0; sync-low counter 0.
- `i_sync_n` rise sampled at edge N in CGS: WAIT_LMFC from edge N (outputs unchanged).
- `i_lmfc_clk` high sampled at edge M in WAIT_LMFC: first ILAS frame (`o_ilas_r`=1, `o_tx_sel`=1) visible after edge M; each subsequent ILAS multiframe starts one cycle after each LMFC pulse, since period = `i_K`+1 = LMFC period.
- ILAS duration exactly `ILAS_MF`*(`i_K`+1) cycles; `o_tx_sel`=2 and `o_link_up`=1 in the next cycle.
- Re-sync: `SYNC_ERR_LEN`-th consecutive low sampled at edge P -> `o_tx_sel`=0, `o_link_up`=0 after edge P.
- Simultaneous re-sync and ILAS completion at the same edge: CGS wins.
- `i_sync_n` low and `i_lmfc_clk` high at same edge in WAIT_LMFC: CGS wins.
- `rst` mid-ILAS/DATA: immediate return to reset values, counters cleared.

## Test plan
- Reset, `i_sync_n`=0 for 20 cycles -> `o_tx_sel`=0, `o_link_up`=0 throughout, all markers 0.
- `i_K`=3, default params, release `i_sync_n` -> ILAS starts cycle after next LMFC pulse, 16 ILAS cycles, `o_ilas_r` at frames 0, `o_ilas_a` at frames 3, `o_ilas_q` once (mf 1, frame 1), then `o_link_up`=1.
- In DATA, `i_sync_n` low for 3 cycles -> stays DATA; low for 4 cycles -> `o_tx_sel`=0 after 4th low edge, then relink on later release.
- `i_K`=0 -> ILAS lasts 4 cycles, `o_ilas_r`=`o_ilas_a`=1 each cycle, `o_ilas_q` never set; `i_K`=31 -> 128 ILAS cycles, frame index reaches 31.
- `i_sync_n` drops in WAIT_LMFC on the LMFC-pulse cycle -> CGS, no ILAS; `SYNC_ERR_LEN`-th low coincides with final ILAS frame -> CGS, `o_link_up` never asserts.
- `rst` pulsed mid-ILAS (mf=2, frame=1) -> all outputs to reset values asynchronously, sequence restarts from CGS.
